tank_sprite_fetch: RTL

- Per-pixel front end for the tank/explosion sprite. It sits directly upstream of the 16-entry tank palette lookup (4-bit index to 12-bit RGB).
- Takes VGA draw coordinates and the tank position, and generates the address into a synchronous sprite-index ROM that holds frame 0 (intact tank) followed by the explosion frames.
- Returns a pipelined palette index with valid and opaque flags.
- Owns the explosion animation state machine, which advances frames only on vertical sync.

---
 rtl/tank_sprite_fetch_if.sv | 31 +++
 rtl/tank_sprite_fetch.sv | 136 +++++++++++++
 2 files changed

// File: rtl/tank_sprite_fetch_if.sv
// Pixel/ROM/control bundle between the VGA front end and the tank sprite fetch stage.
// The slave side is the sprite fetch block; the master side drives pixels and controls and holds the ROM.
interface tank_sprite_fetch_if #(
  parameter int ROM_AW = 13
) ();
  logic              pix_en;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              vsync_pulse;
  logic [9:0]        tank_x;
  logic [9:0]        tank_y;
  logic              explode;
  logic              respawn;
  logic [ROM_AW-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic [3:0]        index;
  logic              pix_valid;
  logic              opaque;
  logic              anim_busy;
  logic              anim_done;

  modport master (
    output pix_en, DrawX, DrawY, vsync_pulse, tank_x, tank_y, explode, respawn, rom_data,
    input  rom_addr, index, pix_valid, opaque, anim_busy, anim_done
  );

  modport slave (
    input  pix_en, DrawX, DrawY, vsync_pulse, tank_x, tank_y, explode, respawn, rom_data,
    output rom_addr, index, pix_valid, opaque, anim_busy, anim_done
  );
endinterface

// File: rtl/tank_sprite_fetch.sv
// Tank/explosion sprite front end: hit test, sprite ROM addressing, 3-cycle index pipeline
// and the vsync-paced explosion animation FSM.
module tank_sprite_fetch #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int NUM_FRAMES = 7,
  parameter int FRAME_HOLD = 4,
  parameter int ROM_AW     = 13,
  parameter int TRANSP_IDX = 0
) (
  input logic                  Clk,
  input logic                  Reset_n,
  tank_sprite_fetch_if.slave   bus
);
  localparam int LW = $clog2(SPR_W);
  localparam int LH = $clog2(SPR_H);
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [3:0]    TIDX      = 4'(TRANSP_IDX);
  localparam logic [FW-1:0] LAST_FRM  = FW'(NUM_FRAMES - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(FRAME_HOLD - 1);

  typedef enum logic [1:0] {IDLE, EXPLODE, DEAD} state_t;

  state_t            state_q;
  logic [FW-1:0]     frame_q;
  logic [HW-1:0]     hold_q;
  logic              anim_busy_q;
  logic              anim_done_q;

  logic [9:0]        dx, dy;
  logic              hit;
  logic [ROM_AW-1:0] rom_addr_d;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              vld_p1_q, hit_p1_q;
  logic              vld_p2_q, hit_p2_q;
  logic [3:0]        index_q;
  logic              pix_valid_q;
  logic              opaque_q;

  // ---- stage 0: hit test and address (the >= terms reject wrap-around at screen edges)
  assign dx  = bus.DrawX - bus.tank_x;
  assign dy  = bus.DrawY - bus.tank_y;
  assign hit = (bus.DrawX >= bus.tank_x) && (bus.DrawY >= bus.tank_y) &&
               (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));
  assign rom_addr_d = (ROM_AW'(frame_q) << (LW + LH)) |
                      (ROM_AW'(dy[LH-1:0]) << LW) |
                      ROM_AW'(dx[LW-1:0]);

  // ---- stage 1: ROM address issue / stage 2: ROM data / stage 3: palette index out
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q  <= '0;
      vld_p1_q    <= 1'b0;
      hit_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      hit_p2_q    <= 1'b0;
      index_q     <= '0;
      pix_valid_q <= 1'b0;
      opaque_q    <= 1'b0;
    end else begin
      if (hit) rom_addr_q <= rom_addr_d;
      vld_p1_q    <= bus.pix_en;
      hit_p1_q    <= hit;
      vld_p2_q    <= vld_p1_q;
      hit_p2_q    <= hit_p1_q;
      index_q     <= hit_p2_q ? bus.rom_data : TIDX;
      pix_valid_q <= vld_p2_q;
      opaque_q    <= hit_p2_q && (bus.rom_data != TIDX) && (state_q != DEAD);
    end
  end

  // Explosion animation: frames advance only on vsync; respawn has priority over explode.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      hold_q      <= '0;
      anim_busy_q <= 1'b0;
      anim_done_q <= 1'b0;
    end else begin
      anim_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.explode && !bus.respawn) begin
            state_q     <= EXPLODE;
            frame_q     <= FW'(1);
            hold_q      <= '0;
            anim_busy_q <= 1'b1;
          end
        end
        EXPLODE: begin
          if (bus.respawn) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            hold_q      <= '0;
            anim_busy_q <= 1'b0;
          end else if (bus.vsync_pulse) begin
            if (hold_q == LAST_HOLD) begin
              if (frame_q < LAST_FRM) begin
                frame_q <= frame_q + FW'(1);
                hold_q  <= '0;
              end else begin
                state_q     <= DEAD;
                anim_busy_q <= 1'b0;
                anim_done_q <= 1'b1;
              end
            end else begin
              hold_q <= hold_q + HW'(1);
            end
          end
        end
        DEAD: begin
          if (bus.respawn) begin
            state_q <= IDLE;
            frame_q <= '0;
            hold_q  <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          frame_q     <= '0;
          hold_q      <= '0;
          anim_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.index     = index_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.opaque    = opaque_q;
  assign bus.anim_busy = anim_busy_q;
  assign bus.anim_done = anim_done_q;
endmodule
